// File: rtl/alu_gcd_datapath.sv
// alu_gcd_datapath: enable/done execution unit for ADD/SUB/MUL/GCD (ports: clk, reset, enable, opcode, a, b, invalid_opcode -> result, done, result_valid, error, halted, busy)
module alu_gcd_datapath #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [3:0]       opcode,
  input  logic [OP_W-1:0]  a,
  input  logic [OP_W-1:0]  b,
  input  logic             invalid_opcode,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             result_valid,
  output logic             error,
  output logic             halted,
  output logic             busy
);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_GCD, S_DONE} state_t;
  localparam logic [3:0] OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_MUL = 4'b0011, OP_GCD = 4'b1011, OP_HALT = 4'b1111;
  state_t state;
  logic enable_q;
  logic [WIDTH-1:0] acc, mcand, acc_next, a_ext, b_ext;
  logic [OP_W-1:0] mplier, x, y;
  logic [3:0] cnt;
  logic start;
  assign a_ext = {{(WIDTH-OP_W){1'b0}}, a};
  assign b_ext = {{(WIDTH-OP_W){1'b0}}, b};
  assign start = enable & ~enable_q;
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign done = state == S_DONE;
  assign busy = state != S_IDLE;
  assign result_valid = done | error;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      enable_q <= 1'b0;
      result <= '0;
      error <= 1'b0;
      halted <= 1'b0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      x <= '0;
      y <= '0;
      cnt <= '0;
    end else begin
      enable_q <= enable;
      error <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          if (invalid_opcode || !(opcode inside {OP_ADD, OP_SUB, OP_MUL, OP_GCD, OP_HALT})) begin
            result <= '0;
            error <= 1'b1;
          end else if (opcode == OP_HALT) begin
            halted <= 1'b1;
          end else begin
            halted <= 1'b0;
            case (opcode)
              OP_ADD: begin
                result <= a_ext + b_ext;
                state <= S_DONE;
              end
              OP_SUB: begin
                result <= a_ext - b_ext;
                state <= S_DONE;
              end
              OP_MUL: begin
                acc <= '0;
                mcand <= a_ext;
                mplier <= b;
                cnt <= 4'(OP_W);
                state <= S_MUL;
              end
              default: begin
                x <= a;
                y <= b;
                state <= S_GCD;
              end
            endcase
          end
        end
        S_MUL: if (!enable) state <= S_IDLE;
        else begin
          acc <= acc_next;
          mcand <= mcand << 1;
          mplier <= mplier >> 1;
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            result <= acc_next;
            state <= S_DONE;
          end
        end
        S_GCD: if (!enable) state <= S_IDLE;
        else if (x == '0 || y == '0) begin
          result <= {{(WIDTH-OP_W){1'b0}}, x | y};
          state <= S_DONE;
        end else if (x == y) begin
          result <= {{(WIDTH-OP_W){1'b0}}, x};
          state <= S_DONE;
        end else if (x > y) x <= x - y;
        else y <= y - x;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_gcd_datapath.sv
// tb_alu_gcd_datapath: directed self-checking bench for alu_gcd_datapath
module tb_alu_gcd_datapath;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, invalid_opcode = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic [7:0] a = 8'h0, b = 8'h0;
  logic [15:0] result;
  logic done, result_valid, error, halted, busy;
  int n_cmp = 0, n_err = 0;
  int cyc, bsy, acc_n;
  alu_gcd_datapath #(.WIDTH(16), .OP_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .opcode(opcode), .a(a), .b(b),
    .invalid_opcode(invalid_opcode), .result(result), .done(done),
    .result_valid(result_valid), .error(error), .halted(halted), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    opcode = o;
    a = x;
    b = y;
    enable = 1'b1;
  endtask
  task automatic wait_done(input int max, output int c, output int bcount);
    c = 0;
    bcount = 0;
    do begin
      @(negedge clk);
      c++;
      bcount += int'(busy);
    end while (!done && c < max);
  endtask
  task automatic idle();
    enable = 1'b0;
    invalid_opcode = 1'b0;
    @(negedge clk);
  endtask
  task automatic run(input string tag, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                     input int lat, input logic [15:0] exp);
    op(o, x, y);
    wait_done(lat + 4, cyc, bsy);
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_res"}, result, exp);
    idle();
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset_out", {result, done, result_valid, error, halted, busy}, '0);
    reset = 1'b0;
    @(negedge clk);
    op(4'b0001, 8'hFF, 8'h01);
    @(negedge clk);
    chk("add_flags", {done, result_valid, busy, error}, 4'b1110);
    chk("add_res", result, 16'h0100);
    acc_n = 0;
    repeat (3) begin
      @(negedge clk);
      acc_n += int'(done);
    end
    chk("add_single_done", acc_n, 0);
    idle();
    run("sub", 4'b0010, 8'd3, 8'd5, 1, 16'hFFFE);
    op(4'b0011, 8'hFF, 8'hFF);
    wait_done(14, cyc, bsy);
    chk("mul_lat", cyc, 9);
    chk("mul_res", result, 16'hFE01);
    chk("mul_busy", bsy, 9);
    idle();
    chk("mul_busy_off", busy, 1'b0);
    run("gcd_12_8", 4'b1011, 8'd12, 8'd8, 4, 16'd4);
    run("gcd_0_5", 4'b1011, 8'd0, 8'd5, 2, 16'd5);
    run("gcd_0_0", 4'b1011, 8'd0, 8'd0, 2, 16'd0);
    run("gcd_255_1", 4'b1011, 8'd255, 8'd1, 256, 16'd1);
    run("add_3_4", 4'b0001, 8'd3, 8'd4, 1, 16'd7);
    op(4'b0001, 8'd1, 8'd1);
    invalid_opcode = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    invalid_opcode = 1'b0;
    chk("inv_res", result, 16'h0000);
    chk("inv_flags", {result_valid, error, done, busy}, 4'b1100);
    @(negedge clk);
    chk("inv_pulse_end", {result_valid, error}, 2'b00);
    run("add_3_4b", 4'b0001, 8'd3, 8'd4, 1, 16'd7);
    op(4'b0101, 8'd1, 8'd1);
    @(negedge clk);
    enable = 1'b0;
    chk("badop_res", result, 16'h0000);
    chk("badop_flags", {result_valid, error, done, busy}, 4'b1100);
    @(negedge clk);
    run("add_1_6", 4'b0001, 8'd1, 8'd6, 1, 16'd7);
    op(4'b1111, 8'd9, 8'd9);
    @(negedge clk);
    enable = 1'b0;
    chk("halt_flags", {halted, result_valid, done, error, busy}, 5'b10000);
    chk("halt_res", result, 16'd7);
    @(negedge clk);
    op(4'b0001, 8'd2, 8'd2);
    @(negedge clk);
    chk("halt_clear", {halted, done}, 2'b01);
    chk("halt_add_res", result, 16'd4);
    idle();
    op(4'b1011, 8'd255, 8'd1);
    repeat (50) @(negedge clk);
    chk("gcd_busy_mid", busy, 1'b1);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    chk("reset_mid_gcd", {result, done, result_valid, error, halted, busy}, '0);
    reset = 1'b0;
    @(negedge clk);
    run("add_2_3", 4'b0001, 8'd2, 8'd3, 1, 16'd5);
    op(4'b0011, 8'd15, 8'd15);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("abort_idle", busy, 1'b0);
    acc_n = int'(done);
    repeat (10) begin
      @(negedge clk);
      acc_n += int'(done);
    end
    chk("abort_no_done", acc_n, 0);
    chk("abort_res", result, 16'd5);
    reset = 1'b1;
    op(4'b0001, 8'd1, 8'd1);
    @(negedge clk);
    chk("reset_wins", {result, done, busy}, '0);
    reset = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
